// File: rtl/mb_io_pkg.sv
// Shared definitions for the MicroBlaze MCS IO-bus initiator.
//   mb_io_state_e       : transaction FSM states
//   MbIoTimeoutDefault  : default cycles to wait for IO_Ready after the strobe
//   MbIoDataW / MbIoBeW : IO bus data and byte-enable widths
package mb_io_pkg;

  localparam int unsigned MbIoTimeoutDefault = 255;
  localparam int unsigned MbIoDataW          = 32;
  localparam int unsigned MbIoBeW            = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StWait,
    StResp
  } mb_io_state_e;

endpackage

// File: rtl/mb_io_master.sv
// IO-bus initiator for the MicroBlaze MCS IO protocol. Takes one command at a time on a
// valid/ready interface, issues a single-cycle strobe, waits for IO_Ready (with timeout)
// and returns read data and an error flag on a valid/ready response interface.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake
//   cmd_write/addr/be/wdata        : command fields
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata/rsp_error            : response payload (error = timeout)
//   busy                           : transaction in flight
//   IO_*                           : MCS IO bus towards the slave
// All outputs are driven straight from flops.
module mb_io_master
  import mb_io_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MbIoTimeoutDefault,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [MbIoDataW-1:0] cmd_addr,
  input  logic [MbIoBeW-1:0]   cmd_be,
  input  logic [MbIoDataW-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MbIoDataW-1:0] rsp_rdata,
  output logic                 rsp_error,
  output logic                 busy,
  output logic                 IO_Addr_Strobe,
  output logic                 IO_Read_Strobe,
  output logic                 IO_Write_Strobe,
  output logic [MbIoDataW-1:0] IO_Address,
  output logic [MbIoBeW-1:0]   IO_Byte_Enable,
  output logic [MbIoDataW-1:0] IO_Write_Data,
  input  logic [MbIoDataW-1:0] IO_Read_Data,
  input  logic                 IO_Ready
);

  // The timer counts completed WAIT cycles; reaching this value on a WAIT cycle without
  // IO_Ready means TIMEOUT_CYCLES cycles have elapsed since the strobe.
  localparam logic [TIMEOUT_W-1:0] TimerLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  mb_io_state_e         state_q, state_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 is_write_q, is_write_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [MbIoDataW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_error_q, rsp_error_d;
  logic                 as_q, as_d;
  logic                 rs_q, rs_d;
  logic                 ws_q, ws_d;
  logic [MbIoDataW-1:0] addr_q, addr_d;
  logic [MbIoBeW-1:0]   be_q, be_d;
  logic [MbIoDataW-1:0] wdata_q, wdata_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    is_write_d  = is_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    as_d        = 1'b0;
    rs_d        = 1'b0;
    ws_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d    = StStrobe;
          is_write_d = cmd_write;
          addr_d     = cmd_addr;
          be_d       = cmd_be;
          wdata_d    = cmd_write ? cmd_wdata : '0;
          // Strobes are registered, so they are raised on the edge entering STROBE.
          as_d       = 1'b1;
          ws_d       = cmd_write;
          rs_d       = ~cmd_write;
        end
      end
      StStrobe: begin
        // IO_Ready is deliberately not looked at here.
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + TIMEOUT_W'(1);
        if (IO_Ready) begin
          rsp_rdata_d = is_write_q ? '0 : IO_Read_Data;
          rsp_error_d = 1'b0;
          state_d     = StResp;
        end else if (timer_q == TimerLast) begin
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
    endcase

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      is_write_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      as_q        <= 1'b0;
      rs_q        <= 1'b0;
      ws_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      is_write_q  <= is_write_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      as_q        <= as_d;
      rs_q        <= rs_d;
      ws_q        <= ws_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign busy            = busy_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_error       = rsp_error_q;
  assign IO_Addr_Strobe  = as_q;
  assign IO_Read_Strobe  = rs_q;
  assign IO_Write_Strobe = ws_q;
  assign IO_Address      = addr_q;
  assign IO_Byte_Enable  = be_q;
  assign IO_Write_Data   = wdata_q;

endmodule

// File: tb/tb_mb_io_master.sv
// Self-checking bench for mb_io_master with a short timeout. Each transaction's expected
// response cycle and payload come from a small arithmetic model of the protocol timing.
module tb_mb_io_master;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0] rsp_rdata;
  logic        IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe;
  logic [31:0] IO_Address, IO_Write_Data, IO_Read_Data;
  logic [3:0]  IO_Byte_Enable;
  logic        IO_Ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mb_io_master #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_W     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_be         (cmd_be),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .busy           (busy),
    .IO_Addr_Strobe (IO_Addr_Strobe),
    .IO_Read_Strobe (IO_Read_Strobe),
    .IO_Write_Strobe(IO_Write_Strobe),
    .IO_Address     (IO_Address),
    .IO_Byte_Enable (IO_Byte_Enable),
    .IO_Write_Data  (IO_Write_Data),
    .IO_Read_Data   (IO_Read_Data),
    .IO_Ready       (IO_Ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_error"}, {31'd0, rsp_error}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_strobes"}, {29'd0, IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe}, 32'd0);
    chk({tag, "_addr"}, IO_Address, 32'd0);
    chk({tag, "_be"}, {28'd0, IO_Byte_Enable}, 32'd0);
    chk({tag, "_wdata"}, IO_Write_Data, 32'd0);
  endtask

  // rk >= 0 : slave raises IO_Ready on the rk-th cycle after the strobe cycle
  // rk == -1: slave raises IO_Ready only during the strobe cycle
  // other   : slave never answers
  // Called on a falling edge with the DUT idle; returns on a falling edge, idle again.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] sd, input int rk,
                     input int hold, input bit keep_valid);
    bit          ok;
    int          lat;
    logic [31:0] erd, ewd;
    ok  = (rk >= 0) && (rk < int'(T));
    lat = ok ? 3 + rk : 2 + int'(T);
    erd = (ok && !wr) ? sd : 32'd0;
    ewd = wr ? wd : 32'd0;

    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_be = be; cmd_wdata = wd;
    @(negedge clk);
    // Strobe cycle. Scramble command inputs to prove the bus holds captured values.
    cmd_valid = keep_valid; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = 4'($urandom);
    chk("strb_as", {31'd0, IO_Addr_Strobe}, 32'd1);
    chk("strb_ws", {31'd0, IO_Write_Strobe}, {31'd0, wr});
    chk("strb_rs", {31'd0, IO_Read_Strobe}, {31'd0, !wr});
    chk("strb_addr", IO_Address, addr);
    chk("strb_be", {28'd0, IO_Byte_Enable}, {28'd0, be});
    chk("strb_wdata", IO_Write_Data, ewd);
    chk("strb_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("strb_busy", {31'd0, busy}, 32'd1);
    IO_Ready = (rk == -1); IO_Read_Data = $urandom;
    for (int t = 2; t < lat; t++) begin
      @(negedge clk);
      chk("wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("wait_strobes", {29'd0, IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe}, 32'd0);
      chk("wait_addr", IO_Address, addr);
      chk("wait_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      IO_Ready     = (rk == t - 2);
      IO_Read_Data = (rk == t - 2) ? sd : $urandom;
    end
    @(negedge clk);
    IO_Ready = 1'b0;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_rdata", rsp_rdata, erd);
    chk("rsp_error", {31'd0, rsp_error}, {31'd0, !ok});
    chk("rsp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rsp_bus_addr", IO_Address, addr);
    chk("rsp_bus_wdata", IO_Write_Data, ewd);
    for (int h = 0; h < hold; h++) begin
      IO_Ready = 1'($urandom); IO_Read_Data = $urandom;  // late slave pulses are ignored
      @(negedge clk);
      IO_Ready = 1'b0;
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, erd);
      chk("hold_rsp_error", {31'd0, rsp_error}, {31'd0, !ok});
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; IO_Read_Data = '0; IO_Ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Write, slave answers on the first cycle after the strobe.
    txn(1'b1, 32'h0000_0004, 4'hF, 32'hA5A5_1234, 32'hDEAD_BEEF, 0, 0, 1'b0);
    // Read, slave answers after 5 wait cycles.
    txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hCAFE_F00D, 5, 0, 1'b0);
    // Timeout, slave silent; late pulses arrive during response hold.
    txn(1'b0, 32'h0000_0020, 4'h3, 32'h0, 32'h1234_5678, -99, 3, 1'b0);
    // Next command proceeds normally.
    txn(1'b0, 32'h0000_0024, 4'hF, 32'h0, 32'h0BAD_CAFE, 1, 0, 1'b0);
    // Backpressure with cmd_valid held high.
    txn(1'b0, 32'h0000_0030, 4'hF, 32'h0, 32'h1111_2222, 2, 6, 1'b1);
    // IO_Ready only during the strobe cycle: must time out.
    txn(1'b0, 32'h0000_0040, 4'hC, 32'h0, 32'h5555_AAAA, -1, 0, 1'b0);
    // IO_Ready coinciding with the last cycle before timeout wins.
    txn(1'b0, 32'h0000_0044, 4'hF, 32'h0, 32'h7777_8888, int'(T) - 1, 0, 1'b0);

    // Reset while waiting.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("wait_reset");
    IO_Ready = 1'b1; IO_Read_Data = 32'hFFFF_0000;
    @(negedge clk);
    IO_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
    end

    // Randomised transactions; rk beyond T-1 produces timeouts.
    for (int n = 0; n < 25; n++) begin
      txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
          int'($urandom_range(0, T + 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mb_io_master.md
Name: mb_io_master

Overview:
- IO-bus initiator for the MicroBlaze MCS IO protocol. It lets fabric logic, or a test harness, drive transactions into IO slaves such as mb_io_slave without the CPU.
- It accepts one command at a time on a valid/ready interface and drives the Addr/Read/Write strobes.
- It waits for IO_Ready, guarded by a timeout, and returns read data plus an error flag on a valid/ready response interface.
- It sits beside the MCS in top-level designs, with bus ownership muxed by the integrator.

Parameters:
- TIMEOUT_CYCLES, 255: cycles after the strobe cycle to wait for IO_Ready before flagging an error.
- TIMEOUT_W, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_be  in  4  byte enables
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes and timeouts)
- rsp_error  out  1  1 = timeout, no IO_Ready seen
- busy  out  1  high whenever state is not IDLE
- IO_Addr_Strobe  out  1  address strobe
- IO_Read_Strobe  out  1  read strobe
- IO_Write_Strobe  out  1  write strobe
- IO_Address  out  32  bus address
- IO_Byte_Enable  out  4  bus byte enables
- IO_Write_Data  out  32  bus write data
- IO_Read_Data  in  32  slave read data
- IO_Ready  in  1  slave completion

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - All strobes, rsp_valid, rsp_error and busy = 0.
  - rsp_rdata, IO_Address, IO_Byte_Enable and IO_Write_Data = 0.
  - cmd_ready = 1 (state IDLE).
- States: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, capture the command into IO_Address, IO_Byte_Enable and IO_Write_Data. IO_Write_Data is forced to 0 for reads.
  - Go to STROBE.
- STROBE (exactly one cycle):
  - IO_Addr_Strobe = 1.
  - IO_Write_Strobe = cmd_write; IO_Read_Strobe = !cmd_write.
  - Timer cleared. IO_Ready in this cycle is ignored.
  - Next state is WAIT.
- WAIT:
  - Strobes are 0 and the timer increments each cycle.
  - IO_Ready = 1: latch rsp_rdata (IO_Read_Data for reads, 0 for writes), set rsp_error = 0, go to RESP.
  - Otherwise, when the timer equals TIMEOUT_CYCLES: set rsp_rdata = 0 and rsp_error = 1, go to RESP.
  - If IO_Ready coincides with the timeout cycle, IO_Ready wins (no error).
- RESP:
  - rsp_valid = 1 and held, with rsp_rdata and rsp_error stable, until rsp_ready.
  - On handshake: rsp_valid = 0 next cycle, state returns to IDLE.
  - IO_Ready pulses arriving in RESP or IDLE (late slave after timeout) are ignored.
- Bus output stability: IO_Address, IO_Byte_Enable and IO_Write_Data are held from the STROBE cycle until return to IDLE, and are updated only on command accept.
- Latency:
  - Accept at cycle N, strobe at N+1.
  - Earliest IO_Ready at N+2, giving rsp_valid at N+3.
  - With rsp_ready held high, the next accept is at N+4.
  - Timeout response: rsp_valid at N+2+TIMEOUT_CYCLES.
- Constraints:
  - No command pipelining: one outstanding transaction.
  - cmd_ready = 0 in STROBE, WAIT and RESP.
- Reset mid-transaction: the next edge returns all state and outputs to reset values and drops any pending response. A subsequent IO_Ready is ignored.

Decomposition:
- Package mb_io_pkg holds:
  - the state enum (IDLE, STROBE, WAIT, RESP)
  - a default timeout constant (255)
  - the IO data width constant (32) and byte-enable width (4)
- No sub-module. The timeout counter is inline.

Test Plan:
- Write with a slave that asserts IO_Ready one cycle after the strobe:
  - Stimulus: cmd addr 0x0000_0004, be 0xF, wdata 0xA5A5_1234.
  - Required: exactly one cycle with Addr and Write strobes high and the address/data held on the bus; rsp_valid at N+3 with rdata 0 and error 0.
- Read with a slave that returns 0xCAFE_F00D after 5 wait cycles:
  - Required: rsp_rdata = 0xCAFE_F00D, rsp_error = 0; Read_Strobe is a single-cycle pulse.
- Timeout: TIMEOUT_CYCLES = 8 and the slave never responds.
  - Required: rsp_valid with error = 1 and rdata = 0, 10 cycles after accept.
  - A late IO_Ready then has no effect, and the next command proceeds normally.
- Backpressure: hold rsp_ready low for 6 cycles after a read of 0x1111_2222.
  - Required: rsp_valid, rdata and error are stable; cmd_ready stays 0 even while cmd_valid is held high.
- Reset in WAIT: assert reset for 1 cycle.
  - Required: all outputs at reset values on the next cycle, cmd_ready = 1, and no response is emitted even if IO_Ready pulses afterward.
- IO_Ready during the STROBE cycle only:
  - Required: it is ignored and the block still waits; a timeout occurs if no later IO_Ready arrives.
